// File: rtl/arbitration_logic_wrr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // A zero weight still grants one transfer so a requester can never be starved by its own config.
    function automatic logic [31:0] arb_quantum(input logic [31:0] w);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/arbitration_logic_fixed.sv
// Fixed-priority picker: the lowest set request index wins.
module arbitration_logic_fixed #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IW'(i);
            end
        end
    end

endmodule

// File: rtl/arbitration_logic_wrr_rr_pick.sv
// Rotating-priority picker: the lowest request above `last` wins, else the lowest request overall.
module rr_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic [N-1:0]  mask;
    logic [N-1:0]  masked_req;
    logic [N-1:0]  m_onehot;
    logic [N-1:0]  a_onehot;
    logic [IW-1:0] m_idx;
    logic [IW-1:0] a_idx;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i > int'(last));
        end
    end

    assign masked_req = req & mask;

    arbitration_logic_fixed #(.N(N), .IW(IW)) u_masked (
        .req    (masked_req),
        .onehot (m_onehot),
        .idx    (m_idx)
    );

    arbitration_logic_fixed #(.N(N), .IW(IW)) u_all (
        .req    (req),
        .onehot (a_onehot),
        .idx    (a_idx)
    );

    assign onehot = (|masked_req) ? m_onehot : a_onehot;
    assign idx    = (|masked_req) ? m_idx    : a_idx;

endmodule

// File: rtl/arbitration_logic_wrr.sv
// Weighted round-robin arbiter with grant hold and registered one-hot grant.
// Define ARB_WRR_BACK2BACK_EN to re-arbitrate on the release edge (no idle bubble).
//
// state | meaning
// IDLE  | no grant; arbitrate when any req is set
// HOLD  | grant held; credit counts down one per ack
module arbitration_logic_wrr
    import arb_pkg::*;
#(
    parameter  int N      = 8,
    parameter  int W_BITS = 4,
    localparam int IW     = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N*W_BITS-1:0] weight,
    input  logic                ack,
    output logic [N-1:0]        grant,
    output logic                grant_valid,
    output logic [IW-1:0]       grant_id
);

    arb_state_t        state_q, state_d;
    logic [N-1:0]      grant_q, grant_d;
    logic              valid_q, valid_d;
    logic [IW-1:0]     id_q, id_d;
    logic [IW-1:0]     last_q, last_d;
    logic [W_BITS-1:0] credit_q, credit_d;

    logic [N-1:0]      pick_onehot;
    logic [IW-1:0]     pick_idx;
    logic [W_BITS-1:0] w_sel;
    logic              load;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req    (req),
        .last   (last_q),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == IW'(i)) begin
                w_sel = weight[i*W_BITS +: W_BITS];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        id_d     = id_q;
        last_d   = last_q;
        credit_d = credit_q;
        load     = 1'b0;
        case (state_q)
            IDLE: load = |req;
            HOLD: begin
                // A dropped request releases even mid-quantum; an ack on that cycle still counts.
                if ((ack && credit_q == W_BITS'(1)) || !req[id_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    id_d    = '0;
`ifdef ARB_WRR_BACK2BACK_EN
                    load    = |req;
`endif
                end else if (ack) begin
                    credit_d = credit_q - W_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d  = HOLD;
            grant_d  = pick_onehot;
            id_d     = pick_idx;
            last_d   = pick_idx;
            credit_d = W_BITS'(arb_quantum(32'(w_sel)));
        end
        valid_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            id_q     <= '0;
            last_q   <= IW'(N - 1);
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            last_q   <= last_d;
            credit_q <= credit_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;

endmodule

// File: tb/tb_arbitration_logic_wrr.sv
// Scoreboard bench for arbitration_logic_wrr; expected transfer owners are queued per test.
module tb_arbitration_logic_wrr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  req = '0;
    logic [31:0] weight = 32'h1111_1111;
    logic        ack = 1'b0;
    logic [7:0]  grant;
    logic        grant_valid;
    logic [2:0]  grant_id;

    int vectors    = 0;
    int miscompares = 0;
    int exp_q[$];
    bit mon_en = 1'b0;
    bit seen   = 1'b0;
    int gaps   = 0;

`ifdef ARB_WRR_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    arbitration_logic_wrr #(.N(8), .W_BITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .weight      (weight),
        .ack         (ack),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Transfer monitor: every grant_valid && ack cycle consumes one expected owner.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (grant_valid && ack) begin
                check("xfer_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    int e;
                    e = exp_q.pop_front();
                    check("xfer_id", 32'(grant_id), 32'(e));
                    check("xfer_onehot", 32'(grant), 32'(8'd1 << e));
                    check("xfer_valid", 32'(grant_valid), 32'(|grant));
                    seen = 1'b1;
                end
            end else if (!grant_valid && seen && exp_q.size() != 0) begin
                gaps++;
            end
        end
    end

    task automatic run_sb(input string tag, input logic [7:0] r, input int exp_gaps);
        int n;
        gaps   = 0;
        seen   = 1'b0;
        mon_en = 1'b1;
        req    = r;
        ack    = 1'b1;
        n      = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        req = '0;
        ack = 1'b0;
        tick();
        tick();
        mon_en = 1'b0;
        check({tag, "_gaps"}, 32'(gaps), 32'(exp_gaps));
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_valid", 32'(grant_valid), 32'd0);
        check("rst_id", 32'(grant_id), 32'd0);
        rst = 1'b0;

        // Reset priority: 0 and 7 alternate starting with 0
        do_reset();
        weight = 32'h1111_1111;
        exp_q = '{0, 7, 0, 7};
        run_sb("prio", 8'h81, B2B ? 0 : 3);

        // Weighting: 0x1, 1x2, 2x3, 3x1, two rounds
        do_reset();
        weight = 32'h1111_1321;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(0);
            exp_q.push_back(1); exp_q.push_back(1);
            exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2);
            exp_q.push_back(3);
        end
        run_sb("wrr", 8'h0F, B2B ? 0 : 7);

        // Zero weight behaves as one
        do_reset();
        weight = 32'h1111_1011;
        exp_q = '{2, 2, 2};
        run_sb("zero_w", 8'h04, B2B ? 0 : 2);

        // Maximum quantum of 15
        do_reset();
        weight = 32'h1111_111F;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 15; k++) exp_q.push_back(0);
            exp_q.push_back(1);
        end
        run_sb("max_w", 8'h03, B2B ? 0 : 3);

        // Early drop without ack
        do_reset();
        weight = 32'h1111_1131;
        req = 8'h02;
        tick();
        check("drop_grant", 32'(grant), 32'h02);
        req = 8'h05;
        tick();
        if (B2B) begin
            check("drop_next", 32'(grant), 32'h04);
        end else begin
            check("drop_release", 32'(grant), 32'h00);
            tick();
            check("drop_next", 32'(grant), 32'h04);
        end

        // Ack ignored in IDLE and absent acks do not consume credit
        do_reset();
        weight = 32'h1111_1121;
        ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle_ack", 32'(grant), 32'h00);
        end
        ack = 1'b0;
        req = 8'h02;
        tick();
        check("stall_grant", 32'(grant), 32'h02);
        req = 8'h03;
        weight = 32'h1111_1111;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold", 32'(grant), 32'h02);
        end
        ack = 1'b1;
        tick();
        check("credit_one_left", 32'(grant), 32'h02);
        tick();
        ack = 1'b0;
        if (B2B) begin
            check("credit_release", 32'(grant), 32'h01);
        end else begin
            check("credit_release", 32'(grant), 32'h00);
            tick();
            check("after_release", 32'(grant), 32'h01);
        end

        // Reset mid-hold restarts priority from index 0
        do_reset();
        weight = 32'h1111_2111;
        req = 8'h08;
        tick();
        check("mid_grant", 32'(grant), 32'h08);
        req = 8'h89;
        rst = 1'b1;
        tick();
        check("mid_rst_grant", 32'(grant), 32'h00);
        check("mid_rst_id", 32'(grant_id), 32'd0);
        rst = 1'b0;
        tick();
        check("mid_rearb", 32'(grant), 32'h01);
        req = '0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arbitration_logic_wrr.md
# arbitration_logic_wrr

Weighted round-robin arbiter with grant hold. It replaces the plain round-robin arbiter wherever a winner must keep the shared resource for several transfers. Each requester receives up to `weight[i]` acknowledged transfers per turn before priority rotates. It sits between the engine request lines and the shared memory/bus port, with a registered one-hot grant.

## Interface
- `N`, 8: number of requesters, N ≥ 2.
- `W_BITS`, 4: width of each per-requester weight field.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  N: request vector; bit i is held high while requester i wants service.
- `weight`  in  N*W_BITS: per-requester quantum; field i is `weight[i*W_BITS +: W_BITS]`; value 0 is treated as 1.
- `ack`  in  1: downstream consumed one transfer from the granted requester this cycle.
- `grant`  out  N: registered one-hot grant; all zeros when idle.
- `grant_valid`  out  1: equals `|grant`.
- `grant_id`  out  $clog2(N): index of the granted requester; 0 when idle.

## Operation
- State machine has two states: IDLE and HOLD.
- Internal registers:
  - `last` holds the index of the previous winner; reset value N-1, so index 0 has top priority first.
  - `credit` is W_BITS wide.
- IDLE:
  - If `req` is 0, remain in IDLE.
  - Otherwise pick the winner by rotating priority: the lowest index above `last` whose req bit is set; if there is none, the lowest set index overall.
  - Register `grant`/`grant_id`, set `last` to the winner, load `credit = max(weight[winner],1)`, and go to HOLD.
- HOLD:
  - `ack` with `credit > 1`: decrement `credit`, stay in HOLD.
  - `ack` with `credit == 1`: release.
  - `req[grant_id]` low with no `ack`: release, with no credit consumed.
  - `req[grant_id]` low together with `ack`: the transfer counts, then release.
- Release: clear `grant`/`grant_valid`, reset `grant_id` to 0, go to IDLE. Behaviour with `ARB_WRR_BACK2BACK_EN` is given under Configuration.
- Sampling rules:
  - `weight` is sampled only at grant load; changes during HOLD are ignored.
  - `req` bits of non-granted requesters are ignored during HOLD.
  - `ack` in IDLE is ignored.
- `grant` is always one-hot or zero; it never changes except at load or release.

## Timing
- Reset: `grant`=0, `grant_valid`=0, `grant_id`=0, state IDLE, `credit`=0, `last`=N-1. Reset asserted during HOLD drops the grant on the next edge; no credit or pointer state survives.
- Latency: `req` rising in IDLE at cycle t gives `grant` at t+1.
- `ack` is sampled on the same edge as `grant`. A transfer completes in every cycle where `grant_valid && ack`.
- Release timing (without the macro):
  - `grant` falls one cycle after the final ack, then there is one idle bubble cycle.
  - The next grant appears two cycles after the final ack.
- Maximum sustained hold per turn is `2^W_BITS - 1` transfers.

## Configuration
- `ARB_WRR_BACK2BACK_EN` defined:
  - On release, arbitration happens on the same edge as the release.
  - The new winner is chosen with `last` already equal to the releasing index, so the releasing requester can win again only if it is the sole requester.
  - No bubble: the next grant is valid in the cycle right after the final ack.
- Undefined: the one-cycle IDLE bubble described above.
- Grant ordering and credit behaviour are identical in both builds.

## Structure
- Shared package `arb_pkg`:
  - `arb_state_t` enum {IDLE, HOLD}.
  - Function `arb_quantum(w)`, which clamps 0 to 1.
- Sub-module `rr_pick`:
  - Combinational rotating-priority picker with inputs `req`, `last` and outputs `onehot`, `idx`.
  - Built from a thermometer mask over `last` and two `arbitration_logic_fixed` instances (masked and unmasked requests), with the masked result taking precedence when nonzero.
- Top level holds the FSM, `credit` counter, `last` register and output registers.

## Test plan
- Reset priority: after reset, `req=8'b1000_0001`, weights 1, `ack` held high → grants go 0, 7, 0, 7; no-macro build shows a bubble between each.
- Weighting: N=4, `weight={4'd1,4'd3,4'd2,4'd1}` (requesters 3..0), all req high, `ack` high → grant sequence per round is 0×1, 1×2, 2×3, 3×1, repeating.
- Zero weight: `weight[2]=0`, only req 2 high, `ack` high → each hold lasts exactly 1 transfer.
- Early drop: grant to 1 with credit 3, `req[1]` falls with no ack → `grant` is 0 on the next cycle, and the next winner is 2 when 2 and 0 request.
- Ack ignored: `ack` pulses in IDLE and while the granted req stalls with no ack → credit is unchanged and no grant change occurs.
- Reset mid-hold: `rst` pulsed during HOLD with credit 2 → `grant`=0 on the next cycle, and re-arbitration restarts from index 0. With `ARB_WRR_BACK2BACK_EN`, the same weighting test shows no zero cycles in `grant_valid`.
